uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Receive-side counterpart to the result-transmit path. Parses framed bytes arriving from the UART receiver (received/rx_byte/recv_error) and writes the payload into the program byte memory.
- On a valid checksum it pulses start_program so the program runner begins execution.
- Sits between the UART instance and the program memory write port in the top level.

Parameters:
- ADDR_W, 8, program memory address width; maximum payload is 2**ADDR_W bytes, capped at 255 by the length field.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 120000, maximum idle clk cycles between bytes inside a frame (10 ms at 12 MHz).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- rx_valid  input  1  one-cycle pulse; rx_byte is valid in that cycle (from UART received)
- rx_byte  input  8  received byte
- rx_error  input  1  one-cycle pulse; UART framing error
- mem_we  output  1  program memory write enable
- mem_addr  output  ADDR_W  program memory write address
- mem_wdata  output  8  program memory write data
- busy  output  1  high while a frame is in progress (any state except IDLE)
- start_program  output  1  one-cycle pulse after a good frame
- load_error  output  1  one-cycle pulse on frame abort
- error_code  output  2  cause of the last abort; held until the next abort or reset

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; counters and checksum cleared. Reset mid-frame discards the frame with no error pulse. Memory contents are not touched.
- Frame format: HEADER, LEN (1..min(255, 2**ADDR_W)), LEN payload bytes, CSUM. CSUM = XOR of LEN and all payload bytes.
- IDLE:
  - rx_valid with rx_byte==HEADER -> LEN.
  - rx_valid with any other byte is ignored.
  - rx_error is ignored; no error pulse.
- LEN:
  - rx_valid with byte 0 or byte > 2**ADDR_W -> abort, code 1.
  - Otherwise store the count, checksum=LEN, addr=0 -> DATA.
- DATA:
  - Each rx_valid registers mem_we=1, mem_addr=current index, mem_wdata=rx_byte in the next cycle. mem_we is a single-cycle pulse per byte.
  - Checksum ^= byte; index++.
  - After LEN bytes -> CSUM.
  - HEADER value inside DATA is plain data.
- CSUM:
  - rx_valid with byte==checksum -> start_program=1 next cycle, then IDLE.
  - Mismatch -> abort, code 2.
  - Memory writes already made are not rolled back.
- Timeout: a cycle counter resets on every rx_valid and on entry to LEN. In LEN/DATA/CSUM, when the counter reaches TIMEOUT_CYCLES -> abort, code 3.
- rx_error in LEN/DATA/CSUM -> abort, code 3. rx_error takes priority over rx_valid in the same cycle.
- Abort: load_error=1 for one cycle, error_code updated in the same cycle, state -> IDLE. A byte arriving in the abort cycle is not parsed. The next HEADER starts a fresh frame.
- Latency: last checksum byte rx_valid at cycle T -> start_program high at T+1. Data byte at T -> mem_we at T+1.
- busy rises the cycle after the HEADER is accepted and falls the cycle start_program or load_error is asserted.
- start_program and load_error are never asserted together.

Test Plan:
- Good frame A5 03 11 22 33 03 (03^11^22^33=03) -> writes addr0=11, addr1=22, addr2=33, one mem_we each, start_program one pulse one cycle after the final byte, load_error=0.
- Bad checksum A5 02 AA 55 00 -> two writes, then load_error pulse, error_code=2, no start_program; a following good frame succeeds.
- Length errors: A5 00 -> load_error, code 1, no writes. With ADDR_W=4, A5 11 -> code 1.
- Timeout: A5 02 10, then silence for TIMEOUT_CYCLES -> load_error, code 3, busy=0. At TIMEOUT_CYCLES-1 with byte 20 arriving, no abort.
- Noise and framing: bytes 00 FF 5A in IDLE -> ignored. rx_error in IDLE -> no pulse. rx_error during DATA -> code 3. Payload byte A5 is stored as data.
- Reset mid-frame: rst_n low after A5 02 10 -> outputs 0, IDLE, no error pulse. The next full frame loads normally from addr 0.

Source files
------------

// File: rtl/uart_program_loader.sv
// Frame parser between the UART receiver and the program memory write port.
// Accepts HEADER, LEN, LEN payload bytes, XOR checksum; starts the program on a good frame.
module uart_program_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              start_program,
  output logic              load_error,
  output logic [1:0]        error_code
);

  localparam int unsigned MAX_LEN = (ADDR_W >= 8) ? 255 : (1 << ADDR_W);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CSUM} state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               mem_we_d, busy_d, start_d, lerr_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         mem_wdata_d;
  logic [1:0]         ecode_d;
  logic               abort;
  logic [1:0]         abort_code;

  // Next-state and next-output logic; rx_error beats rx_valid, which beats the timeout.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    timer_d     = (state_q == S_IDLE) ? '0 : timer_q + TMR_W'(1);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    start_d     = 1'b0;
    lerr_d      = 1'b0;
    ecode_d     = error_code;
    abort       = 1'b0;
    abort_code  = 2'd0;

    if (rx_valid) timer_d = '0;

    if (state_q == S_IDLE) begin
      if (rx_valid && rx_byte == HEADER) state_d = S_LEN;
    end else if (rx_error) begin
      abort      = 1'b1;
      abort_code = 2'd3;
    end else if (rx_valid) begin
      case (state_q)
        S_LEN: begin
          if (rx_byte == 8'd0 || 32'(rx_byte) > MAX_LEN) begin
            abort      = 1'b1;
            abort_code = 2'd1;
          end else begin
            len_d   = rx_byte;
            csum_d  = rx_byte;
            idx_d   = 8'd0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(idx_q);
          mem_wdata_d = rx_byte;
          csum_d      = csum_q ^ rx_byte;
          idx_d       = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (rx_byte == csum_q) begin
            start_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            abort      = 1'b1;
            abort_code = 2'd2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      abort      = 1'b1;
      abort_code = 2'd3;
    end

    if (abort) begin
      lerr_d  = 1'b1;
      ecode_d = abort_code;
      state_d = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      timer_q       <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      start_program <= 1'b0;
      load_error    <= 1'b0;
      error_code    <= 2'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      timer_q       <= timer_d;
      mem_we        <= mem_we_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      busy          <= busy_d;
      start_program <= start_d;
      load_error    <= lerr_d;
      error_code    <= ecode_d;
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised bench for uart_program_loader against a frame-level reference model.
module tb_uart_program_loader;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned MAX_LEN = 16;
  localparam logic [7:0]  HDR     = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_error = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              start_program;
  logic              load_error;
  logic [1:0]        error_code;

  uart_program_loader #(.ADDR_W(ADDR_W), .HEADER(HDR), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .start_program(start_program), .load_error(load_error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the frame is kept as a byte list and judged by its position.
  logic [7:0] frame[$];
  bit         in_frame = 1'b0;
  int         gap = 0;
  bit         exp_we = 1'b0, exp_start = 1'b0, exp_lerr = 1'b0, exp_busy = 1'b0;
  logic [7:0] exp_addr = 8'h00, exp_wdata = 8'h00;
  logic [1:0] exp_code = 2'd0;

  logic [7:0] dut_mem[16];
  int         n_start = 0, n_lerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_abort(input logic [1:0] code);
    exp_lerr = 1'b1;
    exp_code = code;
    in_frame = 1'b0;
    frame.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit e, input bit r);
    logic [7:0] x;
    int n;
    exp_we = 1'b0; exp_start = 1'b0; exp_lerr = 1'b0;
    if (!r) begin
      in_frame = 1'b0; frame.delete(); gap = 0;
      exp_addr = 8'h00; exp_wdata = 8'h00; exp_code = 2'd0;
    end else if (!in_frame) begin
      if (v && b == HDR) begin
        in_frame = 1'b1; frame.delete(); frame.push_back(b); gap = 0;
      end
    end else if (e) begin
      model_abort(2'd3);
    end else if (v) begin
      frame.push_back(b);
      gap = 0;
      n = frame.size();
      if (n == 2) begin
        if (b == 8'h00 || int'(b) > MAX_LEN) model_abort(2'd1);
      end else if (n <= 2 + int'(frame[1])) begin
        exp_we = 1'b1; exp_addr = 8'(n - 3); exp_wdata = b;
      end else begin
        x = 8'h00;
        for (int i = 1; i < n - 1; i++) x = x ^ frame[i];
        if (b == x) begin
          exp_start = 1'b1; in_frame = 1'b0; frame.delete();
        end else model_abort(2'd2);
      end
    end else begin
      gap++;
      if (gap == int'(TIMEOUT)) model_abort(2'd3);
    end
    exp_busy = in_frame;
  endtask

  // One clock: drive, let the edge happen, update the model, compare away from the edge.
  task automatic cycle(input bit v, input logic [7:0] b, input bit e, input bit r);
    rx_valid = v; rx_byte = b; rx_error = e; rst_n = r;
    @(posedge clk);
    model_step(v, b, e, r);
    @(negedge clk);
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    end
    check("start_program", 32'(start_program), 32'(exp_start));
    check("load_error", 32'(load_error), 32'(exp_lerr));
    check("busy", 32'(busy), 32'(exp_busy));
    check("error_code", 32'(error_code), 32'(exp_code));
    if (mem_we) dut_mem[mem_addr] = mem_wdata;
    if (start_program) n_start++;
    if (load_error) n_lerr++;
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    cycle(1'b1, b, 1'b0, 1'b1);
    repeat (idle) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic rand_frame(input bit corrupt);
    logic [7:0] len, cs, d;
    len = 8'($urandom_range(1, MAX_LEN));
    cs = len;
    send(HDR, $urandom_range(0, 2));
    send(len, $urandom_range(0, 2));
    for (int i = 0; i < int'(len); i++) begin
      d = 8'($urandom);
      cs = cs ^ d;
      send(d, $urandom_range(0, 2));
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    send(cs, $urandom_range(0, 2));
  endtask

  int s0, l0;

  initial begin
    for (int i = 0; i < 16; i++) dut_mem[i] = 8'h00;
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_error_code", 32'(error_code), 32'd0);
    idle_cycles(2);

    // Good frame
    s0 = n_start; l0 = n_lerr;
    send(HDR, 0); send(8'h03, 1); send(8'h11, 0); send(8'h22, 2); send(8'h33, 0); send(8'h03, 0);
    check("good_start_count", 32'(n_start - s0), 32'd1);
    check("good_lerr_count", 32'(n_lerr - l0), 32'd0);
    check("good_mem0", 32'(dut_mem[0]), 32'h11);
    check("good_mem1", 32'(dut_mem[1]), 32'h22);
    check("good_mem2", 32'(dut_mem[2]), 32'h33);
    idle_cycles(2);

    // Bad checksum, then a good frame
    s0 = n_start; l0 = n_lerr;
    send(HDR, 0); send(8'h02, 0); send(8'hAA, 0); send(8'h55, 0); send(8'h00, 1);
    check("badcs_code", 32'(error_code), 32'd2);
    check("badcs_lerr_count", 32'(n_lerr - l0), 32'd1);
    check("badcs_start_count", 32'(n_start - s0), 32'd0);
    send(HDR, 0); send(8'h01, 0); send(8'h5C, 0); send(8'h5D, 1);
    check("after_badcs_start", 32'(n_start - s0), 32'd1);

    // Length errors and the largest legal length
    send(HDR, 0); send(8'h00, 1);
    check("len0_code", 32'(error_code), 32'd1);
    send(HDR, 0); send(8'h02, 0); send(8'h10, 0); send(8'h20, 0); send(8'h32, 1);
    send(HDR, 0); send(8'h11, 1);
    check("len17_code", 32'(error_code), 32'd1);
    s0 = n_start;
    rand_frame(1'b0);
    send(HDR, 0); send(8'h10, 0);
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    send(8'h10, 1);
    check("len16_start", 32'(n_start - s0), 32'd2);
    check("len16_mem15", 32'(dut_mem[15]), 32'h0F);

    // Timeout: one cycle short of the limit is fine, the full limit aborts
    s0 = n_start;
    send(HDR, 0); send(8'h02, 0); send(8'h10, TIMEOUT - 2); send(8'h20, 0); send(8'h32, 1);
    check("near_timeout_start", 32'(n_start - s0), 32'd1);
    l0 = n_lerr;
    send(HDR, 0); send(8'h02, 0); send(8'h10, TIMEOUT);
    check("timeout_code", 32'(error_code), 32'd3);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_lerr_count", 32'(n_lerr - l0), 32'd1);

    // Noise, rx_error in IDLE, header value as payload, rx_error in DATA
    l0 = n_lerr; s0 = n_start;
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle_cycles(1);
    check("noise_lerr_count", 32'(n_lerr - l0), 32'd0);
    send(HDR, 0); send(8'h03, 0); send(8'h01, 0); send(8'hA5, 0); send(8'h02, 0); send(8'hA5, 1);
    check("hdr_payload_start", 32'(n_start - s0), 32'd1);
    check("hdr_payload_mem1", 32'(dut_mem[1]), 32'hA5);
    send(HDR, 0); send(8'h03, 0); send(8'h01, 0);
    cycle(1'b1, 8'h02, 1'b1, 1'b1);
    idle_cycles(1);
    check("rxerr_data_code", 32'(error_code), 32'd3);

    // Reset mid-frame
    l0 = n_lerr; s0 = n_start;
    send(HDR, 0); send(8'h02, 0); send(8'h10, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_code", 32'(error_code), 32'd0);
    idle_cycles(1);
    send(HDR, 0); send(8'h02, 0); send(8'h77, 0); send(8'h88, 0); send(8'hFD, 1);
    check("midreset_lerr_count", 32'(n_lerr - l0), 32'd0);
    check("midreset_start", 32'(n_start - s0), 32'd1);
    check("midreset_mem0", 32'(dut_mem[0]), 32'h77);

    // Randomised traffic
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 9))
        0: send(8'($urandom), $urandom_range(0, 3));
        1: rand_frame(1'b1);
        2: begin send(HDR, 0); send(8'($urandom_range(17, 255)), 1); end
        3: begin
             send(HDR, 0); send(8'h04, 0);
             cycle($urandom_range(0, 1) == 1, 8'($urandom), 1'b1, 1'b1);
           end
        4: begin send(HDR, 0); send(8'h05, $urandom_range(TIMEOUT - 2, TIMEOUT + 2)); end
        5: begin send(HDR, 0); cycle(1'b0, 8'h00, 1'b0, 1'b0); end
        default: rand_frame(1'b0);
      endcase
    end
    idle_cycles(TIMEOUT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
